memory_access: RTL and testbench

Memory stage of the GCD-CPU pipeline, directly downstream of the execute stage. It consumes the execute stage's registered result (ALU value, destination register, store/load/slt/jump flags, jump target) together with the store operand. It performs data-memory reads and writes against an internal word-addressed RAM, and resolves set-less-than and jump redirects. It registers the write-back bundle for the register file and squashes the younger instructions already in flight behind a taken jump.

---
 rtl/memory_access.sv | 92 +++++++++
 tb/tb_memory_access.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/memory_access.sv
// Memory stage of the GCD-CPU pipeline: data RAM access, slt/jump resolution,
// registered write-back bundle and post-jump squash window.
module memory_access #(
   parameter int ADDR_W   = 8,
   parameter int SQUASH_N = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] ALUout,
   input  logic [4:0]  XM_RD,
   input  logic [31:0] XM_store_data,
   input  logic [1:0]  XM_MemWrite,
   input  logic [1:0]  Load_MEM,
   input  logic [1:0]  slt_control2,
   input  logic [1:0]  J_control2,
   input  logic [31:0] J_address,
   output logic [4:0]  MW_RD,
   output logic [31:0] MW_result,
   output logic        MW_RegWrite,
   output logic        PC_redirect_valid,
   output logic [31:0] PC_redirect_addr,
   output logic        squash_active
);

   localparam logic [0:0] ST_RUN    = 1'b0;
   localparam logic [0:0] ST_SQUASH = 1'b1;
   localparam logic [2:0] SQ_INIT   = 3'(SQUASH_N);

   logic [31:0]       mem [2**ADDR_W];
   logic [ADDR_W-1:0] idx;
   logic [2:0]        sq_cnt;
   logic [0:0]        state;
   logic              accept;
   logic              take_jump;
   logic              do_store;
   logic              do_load;
   logic              do_slt;
   logic              rd_nz;
   logic [31:0]       result_d;
   logic              unused_alu;

   // Byte offset and bits above the word index are don't-care: addresses wrap.
   assign idx        = ALUout[ADDR_W+1:2];
   assign unused_alu = ^ALUout;

   always_comb begin
      state     = (sq_cnt != '0) ? ST_SQUASH : ST_RUN;
      accept    = (state == ST_RUN);
      take_jump = accept && (J_control2 != '0);
      do_store  = accept && !take_jump && (XM_MemWrite != '0);
      do_load   = accept && !take_jump && (XM_MemWrite == '0) && (Load_MEM != '0);
      do_slt    = accept && !take_jump && (XM_MemWrite == '0) && (Load_MEM == '0)
                  && (slt_control2 != '0);
      rd_nz     = (XM_RD != '0);
      if (do_load)
         result_d = mem[idx];
      else if (do_slt)
         result_d = {31'd0, ALUout[31]};
      else
         result_d = ALUout;
   end

   always_ff @(posedge clk) begin
      if (!rst && do_store)
         mem[idx] <= XM_store_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         MW_RD             <= '0;
         MW_result         <= '0;
         MW_RegWrite       <= 1'b0;
         PC_redirect_valid <= 1'b0;
         PC_redirect_addr  <= '0;
         sq_cnt            <= '0;
      end else begin
         MW_RD             <= XM_RD;
         MW_result         <= result_d;
         MW_RegWrite       <= accept && !take_jump && !do_store && rd_nz;
         PC_redirect_valid <= take_jump;
         if (take_jump)
            PC_redirect_addr <= J_address;
         if (take_jump)
            sq_cnt <= SQ_INIT;
         else if (sq_cnt != '0)
            sq_cnt <= sq_cnt - 3'd1;
      end
   end

   assign squash_active = (sq_cnt != '0);

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access: directed scenarios plus random traffic
// compared against a word-array / squash-window reference model.
module tb_memory_access;

   localparam int AW    = 8;
   localparam int SQN   = 2;
   localparam int DEPTH = 1 << AW;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ALUout;
   logic [4:0]  XM_RD;
   logic [31:0] XM_store_data;
   logic [1:0]  XM_MemWrite;
   logic [1:0]  Load_MEM;
   logic [1:0]  slt_control2;
   logic [1:0]  J_control2;
   logic [31:0] J_address;
   logic [4:0]  MW_RD;
   logic [31:0] MW_result;
   logic        MW_RegWrite;
   logic        PC_redirect_valid;
   logic [31:0] PC_redirect_addr;
   logic        squash_active;

   always #5 clk = ~clk;

   memory_access #(.ADDR_W(AW), .SQUASH_N(SQN)) dut (
      .clk               (clk),
      .rst               (rst),
      .ALUout            (ALUout),
      .XM_RD             (XM_RD),
      .XM_store_data     (XM_store_data),
      .XM_MemWrite       (XM_MemWrite),
      .Load_MEM          (Load_MEM),
      .slt_control2      (slt_control2),
      .J_control2        (J_control2),
      .J_address         (J_address),
      .MW_RD             (MW_RD),
      .MW_result         (MW_result),
      .MW_RegWrite       (MW_RegWrite),
      .PC_redirect_valid (PC_redirect_valid),
      .PC_redirect_addr  (PC_redirect_addr),
      .squash_active     (squash_active)
   );

   int          vectors     = 0;
   int          miscompares = 0;
   logic [31:0] mem_m [DEPTH];
   int          sq_left     = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Apply one input vector across a rising edge, then check against the model.
   task automatic step(input logic r, input logic [31:0] alu, input logic [4:0] rd,
                       input logic [31:0] sd, input logic [1:0] mw, input logic [1:0] ld,
                       input logic [1:0] sl, input logic [1:0] jc, input logic [31:0] ja);
      logic [31:0] e_res;
      logic        e_we, e_rv, chk_res;
      int          w;
      rst = r; ALUout = alu; XM_RD = rd; XM_store_data = sd; XM_MemWrite = mw;
      Load_MEM = ld; slt_control2 = sl; J_control2 = jc; J_address = ja;
      @(posedge clk);
      #1;
      vectors++;
      w       = int'((alu >> 2) % DEPTH);
      e_res   = 32'd0;
      e_we    = 1'b0;
      e_rv    = 1'b0;
      chk_res = 1'b0;
      if (r) begin
         sq_left = 0;
         chk_res = 1'b1;
         chk("rst_redirect_addr", PC_redirect_addr, 32'd0);
      end else if (sq_left > 0) begin
         sq_left--;
      end else if (jc != 0) begin
         e_rv    = 1'b1;
         sq_left = SQN;
         chk("redirect_addr", PC_redirect_addr, ja);
      end else if (mw != 0) begin
         mem_m[w] = sd;
      end else begin
         chk_res = 1'b1;
         e_we    = (rd != 0);
         if (ld != 0)      e_res = mem_m[w];
         else if (sl != 0) e_res = ($signed(alu) < 0) ? 32'd1 : 32'd0;
         else              e_res = alu;
      end
      chk("MW_RD", 32'(MW_RD), r ? 32'd0 : 32'(rd));
      chk("MW_RegWrite", 32'(MW_RegWrite), 32'(e_we));
      chk("redirect_valid", 32'(PC_redirect_valid), 32'(e_rv));
      chk("squash_active", 32'(squash_active), (sq_left > 0) ? 32'd1 : 32'd0);
      if (chk_res) chk("MW_result", MW_result, e_res);
   endtask

   task automatic st(input logic [31:0] a, input logic [31:0] d);
      step(1'b0, a, 5'd0, d, 2'd1, 2'd0, 2'd0, 2'd0, 32'd0);
   endtask

   task automatic lw(input logic [31:0] a, input logic [4:0] rd);
      step(1'b0, a, rd, 32'd0, 2'd0, 2'd1, 2'd0, 2'd0, 32'd0);
   endtask

   task automatic idle();
      step(1'b0, 32'd0, 5'd0, 32'd0, 2'd0, 2'd0, 2'd0, 2'd0, 32'd0);
   endtask

   function automatic logic [1:0] rflag(input int unsigned pct);
      return ($urandom_range(99) < pct) ? 2'($urandom_range(3, 1)) : 2'd0;
   endfunction

   initial begin
      logic [31:0] a;
      step(1'b1, 32'h0, 5'd7, 32'h0, 2'd0, 2'd0, 2'd0, 2'd0, 32'h0);

      // Fill every word so all later loads have a defined expectation.
      for (int i = 0; i < DEPTH; i++) begin
         a = (32'(i) << 2) | ($urandom & 32'hFFFF_FC03);
         st(a, $urandom);
      end

      // Store/load round trip, offset-insensitive index
      st(32'h10, 32'hDEADBEEF);
      lw(32'h10, 5'd5);
      lw(32'h13, 5'd5);

      // Set-less-than
      step(1'b0, 32'hFFFF_FFFE, 5'd3, 32'h0, 2'd0, 2'd0, 2'd1, 2'd0, 32'h0);
      step(1'b0, 32'h0000_0004, 5'd3, 32'h0, 2'd0, 2'd0, 2'd1, 2'd0, 32'h0);
      step(1'b0, 32'hFFFF_FFFE, 5'd0, 32'h0, 2'd0, 2'd0, 2'd1, 2'd0, 32'h0);

      // Jump: squashed stores must not land, the next store does
      step(1'b0, 32'h0, 5'd1, 32'h0, 2'd0, 2'd0, 2'd0, 2'd1, 32'h40);
      st(32'h20, 32'h1234);
      st(32'h20, 32'h1234);
      lw(32'h20, 5'd4);
      st(32'h20, 32'h1234);
      lw(32'h20, 5'd4);

      // Precedence: jump beats store and load
      step(1'b0, 32'h30, 5'd6, 32'hCAFE_0000, 2'd2, 2'd3, 2'd1, 2'd3, 32'h88);
      idle();
      idle();
      lw(32'h30, 5'd6);

      // Address wrap
      st(32'h400, 32'hA5);
      lw(32'h000, 5'd2);

      // Reset mid-squash; store presented on the reset edge is discarded
      step(1'b0, 32'h0, 5'd1, 32'h0, 2'd0, 2'd0, 2'd0, 2'd2, 32'h100);
      step(1'b1, 32'h50, 5'd9, 32'hBAD0_BAD0, 2'd1, 2'd0, 2'd0, 2'd0, 32'h0);
      lw(32'h50, 5'd9);

      // Random traffic, including occasional resets and jumps
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(63) == 0), $urandom, 5'($urandom), $urandom,
              rflag(30), rflag(30), rflag(30), rflag(8), $urandom);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
